fan_pwm_gen: RTL



---
 rtl/fan_pwm_pkg.sv | 11 +
 rtl/fan_pwm_chan.sv | 50 +++++
 rtl/fan_pwm_gen.sv | 61 ++++++
 3 files changed

// File: rtl/fan_pwm_pkg.sv
// fan_pwm_pkg: shared duty constants, target clamp and duty-to-count conversion
package fan_pwm_pkg;
  localparam int DUTY_W = 7;
  localparam int DUTY_MAX = 100;
  function automatic logic [DUTY_W-1:0] duty_clamp(input logic [DUTY_W-1:0] d);
    return d > DUTY_W'(DUTY_MAX) ? DUTY_W'(DUTY_MAX) : d;
  endfunction
  function automatic logic [31:0] duty_to_cnt(input logic [DUTY_W-1:0] d, input int unsigned period);
    return (32'(d) * period) / 32'(DUTY_MAX);
  endfunction
endpackage

// File: rtl/fan_pwm_chan.sv
// fan_pwm_chan: one phase-offset PWM channel with shadowed compare and soft ramp under FAN_PWM_RAMP_EN
module fan_pwm_chan
  import fan_pwm_pkg::*;
#(
  parameter int PERIOD = 2000,
  parameter int OFFSET = 0
`ifdef FAN_PWM_RAMP_EN
  , parameter int RAMP_STEP = 1
`endif
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              upd,
  input  logic [DUTY_W-1:0] target,
  output logic              pwm,
  output logic [DUTY_W-1:0] duty_cur
);
  localparam int CW = $clog2(PERIOD);
  localparam int AW = CW + 1;
  localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);
  localparam logic [CW-1:0] OFS = CW'(OFFSET);
  logic [CW-1:0] ph;
  logic [AW-1:0] active_cnt;
  logic [AW-1:0] duty_cnt;
  logic [DUTY_W-1:0] tgt;
  logic [DUTY_W-1:0] duty_nxt;
  assign tgt = duty_clamp(target);
  assign duty_cnt = AW'(duty_to_cnt(duty_cur, PERIOD));
`ifdef FAN_PWM_RAMP_EN
  localparam logic [DUTY_W-1:0] STEP = DUTY_W'(RAMP_STEP);
  always_comb
    duty_nxt = duty_cur < tgt ? (tgt - duty_cur > STEP ? duty_cur + STEP : tgt)
                              : (duty_cur - tgt > STEP ? duty_cur - STEP : tgt);
`else
  always_comb
    duty_nxt = tgt;
`endif
  always_ff @(posedge sys_clk)
    if (sys_rst) begin
      ph <= OFS;
      active_cnt <= '0;
      pwm <= 1'b0;
      duty_cur <= '0;
    end else begin
      ph <= ph == LAST ? '0 : ph + 1'b1;
      active_cnt <= ph == LAST ? duty_cnt : active_cnt;
      pwm <= {1'b0, ph} < active_cnt;
      duty_cur <= upd ? duty_nxt : duty_cur;
    end
endmodule

// File: rtl/fan_pwm_gen.sv
// fan_pwm_gen: multi-channel phase-staggered fan PWM generator, soft ramp enabled by FAN_PWM_RAMP_EN
module fan_pwm_gen
  import fan_pwm_pkg::*;
#(
  parameter int CH_NUM = 2,
  parameter int CLK_HZ = 50_000_000,
  parameter int PWM_HZ = 25_000,
  parameter int RAMP_STEP = 1,
  parameter int RAMP_PERIODS = 25
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst,
  input  logic [DUTY_W*CH_NUM-1:0] duty_data,
  output logic [CH_NUM-1:0]        pwm_out,
  output logic [DUTY_W*CH_NUM-1:0] duty_cur,
  output logic                     period_tick
);
  localparam int PERIOD = CLK_HZ / PWM_HZ;
  localparam int CW = $clog2(PERIOD);
  localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);
  logic [CW-1:0] cnt;
  logic upd;
  if (CH_NUM < 1 || CH_NUM > 8 || PERIOD < 100 || PERIOD > 65536 || RAMP_STEP < 1 || RAMP_PERIODS < 1) begin : g_bad_param
    $error("fan_pwm_gen: parameter out of range");
  end
  always_ff @(posedge sys_clk)
    if (sys_rst) begin
      cnt <= '0;
      period_tick <= 1'b0;
    end else begin
      cnt <= cnt == LAST ? '0 : cnt + 1'b1;
      period_tick <= cnt == LAST;
    end
`ifdef FAN_PWM_RAMP_EN
  localparam int RW = RAMP_PERIODS > 1 ? $clog2(RAMP_PERIODS) : 1;
  localparam logic [RW-1:0] RLAST = RW'(RAMP_PERIODS - 1);
  logic [RW-1:0] rdiv;
  always_ff @(posedge sys_clk)
    if (sys_rst) rdiv <= '0;
    else if (period_tick) rdiv <= rdiv == RLAST ? '0 : rdiv + 1'b1;
  assign upd = period_tick && rdiv == RLAST;
`else
  assign upd = period_tick;
`endif
  for (genvar k = 0; k < CH_NUM; k++) begin : g_ch
    fan_pwm_chan #(
      .PERIOD(PERIOD),
      .OFFSET(k * (PERIOD / CH_NUM))
`ifdef FAN_PWM_RAMP_EN
      , .RAMP_STEP(RAMP_STEP)
`endif
    ) u_chan (
      .sys_clk (sys_clk),
      .sys_rst (sys_rst),
      .upd     (upd),
      .target  (duty_data[DUTY_W*k +: DUTY_W]),
      .pwm     (pwm_out[k]),
      .duty_cur(duty_cur[DUTY_W*k +: DUTY_W])
    );
  end
endmodule
